cam_frame_wr_ctrl: RTL and testbench

CAM_FRAME_WR_CTRL -- requirements
Module: cam_frame_wr_ctrl

---
 rtl/cam_frame_wr_if.sv | 29 ++
 rtl/cam_frame_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_cam_frame_wr_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_wr_if.sv
// rtl/cam_frame_wr_if.sv - frame writer handshake bundle (pixel FIFO, burst arbiter, frame control)
interface cam_frame_wr_if;
  logic        frame_req;
  logic        frame_req_ack;
  logic [10:0] fifo_rd_cnt;
  logic        fifo_rd_en;
  logic        burst_req;
  logic        burst_ack;
  logic [27:0] burst_addr;
  logic [7:0]  burst_len;
  logic        burst_data_req;
  logic        burst_done;
  logic [1:0]  rd_frame_idx;
  logic [1:0]  wr_frame_idx;
  logic        frame_done;
  logic        frame_drop;

  modport master (
    input  frame_req, fifo_rd_cnt, burst_ack, burst_data_req, burst_done, rd_frame_idx,
    output frame_req_ack, fifo_rd_en, burst_req, burst_addr, burst_len, wr_frame_idx,
           frame_done, frame_drop
  );

  modport slave (
    output frame_req, fifo_rd_cnt, burst_ack, burst_data_req, burst_done, rd_frame_idx,
    input  frame_req_ack, fifo_rd_en, burst_req, burst_addr, burst_len, wr_frame_idx,
           frame_done, frame_drop
  );
endinterface

// File: rtl/cam_frame_wr_ctrl.sv
// rtl/cam_frame_wr_ctrl.sv - triple-buffered camera frame writer: FIFO -> memory bursts
module cam_frame_wr_ctrl #(
  parameter logic [27:0] BASE_ADDR    = 28'h0000000,
  parameter logic [27:0] FRAME_STRIDE = 28'h0100000,
  parameter int unsigned FRAME_WORDS  = 786432,
  parameter int unsigned BURST_LEN    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  cam_frame_wr_if.master  bus
);

  localparam logic [27:0] FRAME_WORDS_W = 28'(FRAME_WORDS);
  localparam logic [27:0] BURST_W       = 28'(BURST_LEN);
  localparam logic [27:0] BUF1_ADDR     = BASE_ADDR + FRAME_STRIDE;
  localparam logic [27:0] BUF2_ADDR     = BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_WAIT_DATA, S_REQ, S_XFER, S_NEXT
  } state_e;

  state_e      state_q, state_d;
  logic [27:0] word_cnt_q, word_cnt_d;
  logic [27:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  wr_idx_q, wr_idx_d;

  logic [27:0] remain;
  logic [27:0] len_full;
  logic [27:0] frame_base;
  logic [1:0]  idx_p1, idx_p2;
  logic        frame_complete;

  always_comb begin
    remain         = FRAME_WORDS_W - word_cnt_q;
    len_full       = (remain < BURST_W) ? remain : BURST_W;
    frame_complete = (word_cnt_q == FRAME_WORDS_W);
    case (wr_idx_q)
      2'd0:    frame_base = BASE_ADDR;
      2'd1:    frame_base = BUF1_ADDR;
      default: frame_base = BUF2_ADDR;
    endcase
    // (idx+1) mod 3 and (idx+2) mod 3; the latter skips the buffer on display
    idx_p1 = (wr_idx_q == 2'd2) ? 2'd0 : wr_idx_q + 2'd1;
    idx_p2 = (wr_idx_q == 2'd0) ? 2'd2 : wr_idx_q - 2'd1;
  end

  always_comb begin
    state_d            = state_q;
    word_cnt_d         = word_cnt_q;
    addr_d             = addr_q;
    len_d              = len_q;
    wr_idx_d           = wr_idx_q;
    bus.frame_req_ack  = 1'b0;
    bus.fifo_rd_en     = 1'b0;
    bus.burst_req      = 1'b0;
    bus.frame_done     = 1'b0;
    bus.frame_drop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.frame_req) state_d = S_ACK;
      end
      S_ACK: begin
        bus.frame_req_ack = 1'b1;
        wr_idx_d          = (idx_p1 == bus.rd_frame_idx) ? idx_p2 : idx_p1;
        word_cnt_d        = 28'd0;
        state_d           = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (bus.frame_req) begin
          bus.frame_drop = 1'b1;
          state_d        = S_ACK;
        end else if ({17'd0, bus.fifo_rd_cnt} >= len_full) begin
          addr_d  = frame_base + word_cnt_q;
          len_d   = len_full[7:0];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        bus.burst_req = 1'b1;
        if (bus.burst_ack) state_d = S_XFER;
      end
      S_XFER: begin
        bus.fifo_rd_en = bus.burst_data_req;
        if (bus.burst_done) begin
          word_cnt_d = word_cnt_q + {20'd0, len_q};
          state_d    = S_NEXT;
        end
      end
      S_NEXT: begin
        // a completed frame takes precedence; a pending request is served from IDLE
        if (frame_complete) begin
          bus.frame_done = 1'b1;
          state_d        = S_IDLE;
        end else if (bus.frame_req) begin
          bus.frame_drop = 1'b1;
          state_d        = S_ACK;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.burst_addr   = addr_q;
  assign bus.burst_len    = len_q;
  assign bus.wr_frame_idx = wr_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= 28'd0;
      addr_q     <= 28'd0;
      len_q      <= 8'd0;
      wr_idx_q   <= 2'd2;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_idx_q   <= wr_idx_d;
    end
  end

endmodule

// File: tb/tb_cam_frame_wr_ctrl.sv
// tb/tb_cam_frame_wr_ctrl.sv - directed self-checking bench for cam_frame_wr_ctrl
module tb_cam_frame_wr_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cam_frame_wr_if bus ();

  cam_frame_wr_ctrl #(
    .BASE_ADDR    (28'h0000000),
    .FRAME_STRIDE (28'h0001000),
    .FRAME_WORDS  (200),
    .BURST_LEN    (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request_frame(input bit exp_drop);
    bus.frame_req = 1'b1;
    #1;
    chk("frame_drop_on_req", bus.frame_drop, exp_drop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.frame_req_ack) break;
    end
    chk("frame_req_ack", bus.frame_req_ack, 1);
    chk("frame_drop_at_ack", bus.frame_drop, 0);
    bus.frame_req = 1'b0;
    @(negedge clk);
    chk("frame_req_ack_one_cycle", bus.frame_req_ack, 0);
  endtask

  task automatic do_burst(input logic [27:0] a, input logic [7:0] l, input int delay,
                          input bit last, input bit hold_req);
    int n;
    n = 0;
    while (!bus.burst_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("burst_req", bus.burst_req, 1);
    chk("burst_addr", bus.burst_addr, a);
    chk("burst_len", bus.burst_len, l);
    for (int i = 0; i < delay; i++) begin
      bus.burst_data_req = 1'b1;
      #1;
      chk("rd_en_outside_xfer", bus.fifo_rd_en, 0);
      @(negedge clk);
      bus.burst_data_req = 1'b0;
      chk("burst_req_held", bus.burst_req, 1);
      chk("burst_addr_held", bus.burst_addr, a);
      chk("burst_len_held", bus.burst_len, l);
    end
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack = 1'b0;
    chk("burst_req_after_ack", bus.burst_req, 0);
    for (int i = 0; i < int'(l); i++) begin
      bus.burst_data_req = 1'b1;
      #1;
      chk("fifo_rd_en", bus.fifo_rd_en, 1);
      @(negedge clk);
    end
    bus.burst_data_req = 1'b0;
    if (hold_req) begin
      bus.frame_req = 1'b1;
      #1;
      chk("no_drop_in_xfer", bus.frame_drop, 0);
    end
    bus.burst_done = 1'b1;
    #1;
    chk("fifo_rd_en_idle", bus.fifo_rd_en, 0);
    @(negedge clk);
    bus.burst_done = 1'b0;
    chk("frame_done", bus.frame_done, last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n              = 1'b0;
    bus.frame_req      = 1'b0;
    bus.fifo_rd_cnt    = 11'd2047;
    bus.burst_ack      = 1'b0;
    bus.burst_data_req = 1'b0;
    bus.burst_done     = 1'b0;
    bus.rd_frame_idx   = 2'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", bus.frame_req_ack, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_burst_req", bus.burst_req, 0);
    chk("rst_addr", bus.burst_addr, 0);
    chk("rst_len", bus.burst_len, 0);
    chk("rst_wr_idx", bus.wr_frame_idx, 2);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_drop", bus.frame_drop, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // first frame lands in buffer 0
    request_frame(0);
    chk("f1_wr_idx", bus.wr_frame_idx, 0);
    do_burst(28'h000, 8'd64, 0, 0, 0);
    do_burst(28'h040, 8'd64, 0, 0, 0);
    do_burst(28'h080, 8'd64, 0, 0, 0);
    do_burst(28'h0C0, 8'd8, 0, 1, 0);
    @(negedge clk);
    chk("f1_done_pulse_end", bus.frame_done, 0);
    chk("f1_idle_burst_req", bus.burst_req, 0);

    // buffer 1 is on display, so frame 2 goes to buffer 2; slow grant on first burst
    request_frame(0);
    chk("f2_wr_idx", bus.wr_frame_idx, 2);
    do_burst(28'h2000, 8'd64, 10, 0, 0);
    do_burst(28'h2040, 8'd64, 0, 0, 0);
    do_burst(28'h2080, 8'd64, 0, 0, 0);
    do_burst(28'h20C0, 8'd8, 0, 1, 0);
    @(negedge clk);

    // FIFO one word short of a burst
    bus.fifo_rd_cnt = 11'd63;
    request_frame(0);
    chk("f3_wr_idx", bus.wr_frame_idx, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("f3_no_req_at_63", bus.burst_req, 0);
    end
    bus.fifo_rd_cnt = 11'd64;
    do_burst(28'h000, 8'd64, 0, 0, 0);
    do_burst(28'h040, 8'd64, 0, 0, 0);
    bus.fifo_rd_cnt = 11'd0;
    @(negedge clk);
    chk("f3_waiting", bus.burst_req, 0);

    // new request mid-frame drops it and restarts in the next buffer
    request_frame(1);
    chk("f4_wr_idx", bus.wr_frame_idx, 2);
    bus.fifo_rd_cnt = 11'd2047;
    do_burst(28'h2000, 8'd64, 0, 0, 0);
    do_burst(28'h2040, 8'd64, 0, 0, 0);
    do_burst(28'h2080, 8'd64, 0, 0, 0);
    do_burst(28'h20C0, 8'd8, 0, 1, 0);
    @(negedge clk);

    // request held across final burst_done: done wins, request served afterwards
    request_frame(0);
    chk("f5_wr_idx", bus.wr_frame_idx, 0);
    do_burst(28'h000, 8'd64, 0, 0, 0);
    do_burst(28'h040, 8'd64, 0, 0, 0);
    do_burst(28'h080, 8'd64, 0, 0, 0);
    do_burst(28'h0C0, 8'd8, 0, 1, 1);
    chk("f5_no_drop_with_done", bus.frame_drop, 0);
    @(negedge clk);
    chk("f5_idle_no_ack", bus.frame_req_ack, 0);
    chk("f5_idle_done_low", bus.frame_done, 0);
    @(negedge clk);
    chk("f5_late_ack", bus.frame_req_ack, 1);
    bus.frame_req = 1'b0;
    @(negedge clk);
    chk("f6_wr_idx", bus.wr_frame_idx, 2);

    // reset in the middle of a transfer
    n = 0;
    while (!bus.burst_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("f6_burst_req", bus.burst_req, 1);
    chk("f6_burst_addr", bus.burst_addr, 28'h2000);
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack      = 1'b0;
    bus.burst_data_req = 1'b1;
    #1;
    chk("f6_xfer_rd_en", bus.fifo_rd_en, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
    chk("mid_rst_burst_req", bus.burst_req, 0);
    chk("mid_rst_addr", bus.burst_addr, 0);
    chk("mid_rst_len", bus.burst_len, 0);
    chk("mid_rst_wr_idx", bus.wr_frame_idx, 2);
    chk("mid_rst_ack", bus.frame_req_ack, 0);
    chk("mid_rst_done", bus.frame_done, 0);
    chk("mid_rst_drop", bus.frame_drop, 0);
    @(negedge clk);
    rst_n              = 1'b1;
    bus.burst_data_req = 1'b0;
    bus.burst_done     = 1'b1;
    @(negedge clk);
    bus.burst_done     = 1'b0;
    bus.burst_data_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("post_rst_rd_en", bus.fifo_rd_en, 0);
      chk("post_rst_burst_req", bus.burst_req, 0);
      chk("post_rst_done", bus.frame_done, 0);
      chk("post_rst_ack", bus.frame_req_ack, 0);
      @(negedge clk);
    end
    bus.burst_data_req = 1'b0;
    chk("post_rst_wr_idx", bus.wr_frame_idx, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
